// File: rtl/icache_rf_write_ctrl_pkg.sv
// Shared types for the icache register-file write controller.
package icache_rf_wctrl_pkg;

  // Controller phases: power-on clear, normal arbitration, on-demand clear.
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } wctrl_state_e;

endpackage

// File: rtl/icache_rf_write_ctrl_rr_arb.sv
// Combinational round-robin arbiter: scans req upward from ptr (mod N_REQ)
// and returns a one-hot grant plus the index of the granted requester.
module rr_arb_onehot #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  // First set request at or after the pointer wins.
  always_comb begin
    logic [IDX_W-1:0] j;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = IDX_W'((int'(ptr) + i) % N_REQ);
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = j;
      end
    end
  end

endmodule

// File: rtl/icache_rf_write_ctrl.sv
// Write-port owner for the L1 icache tag/valid register file.
// Arbitrates N_REQ writers round-robin and runs zeroing sweeps (init after
// reset, flush on request), one entry per cycle.
// Build option: define ICACHE_RF_WCTRL_SKIP_INIT_EN to come out of reset in
// IDLE (no init sweep) when the register file clears itself on reset.
module icache_rf_write_ctrl
  import icache_rf_wctrl_pkg::*;
#(
  parameter  int ADDR_WIDTH = 5,
  parameter  int DATA_WIDTH = 32,
  parameter  int N_REQ      = 2,
  localparam int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_REQ-1:0]                     req_i,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     addr_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     wdata_i,
  output logic [N_REQ-1:0]                     gnt_o,
  input  logic                                 flush_req_i,
  output logic                                 busy_o,
  output logic                                 rf_we_o,
  output logic [ADDR_WIDTH-1:0]                rf_waddr_o,
  output logic [DATA_WIDTH-1:0]                rf_wdata_o
);

`ifdef ICACHE_RF_WCTRL_SKIP_INIT_EN
  localparam wctrl_state_e RST_STATE = ST_IDLE;
`else
  localparam wctrl_state_e RST_STATE = ST_INIT;
`endif

  wctrl_state_e          state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [IDX_W-1:0]      rr_ptr;
  logic                  flush_pending;

  logic [N_REQ-1:0]      arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;

  logic                  sweep;
  logic                  sweep_last;
  logic                  grant_fire;

  rr_arb_onehot #(.N_REQ(N_REQ)) u_arb (
    .req     (req_i),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign sweep      = (state == ST_INIT) || (state == ST_FLUSH);
  assign sweep_last = sweep && (cnt == '1);

  // Next-state, grant and busy decode; a flush request in IDLE blocks grants.
  always_comb begin
    state_nxt  = state;
    gnt_o      = '0;
    grant_fire = 1'b0;
    busy_o     = sweep;
    unique case (state)
      ST_INIT, ST_FLUSH: begin
        if (sweep_last) begin
          // A pulse landing on the final sweep cycle still earns a re-sweep.
          state_nxt = (flush_pending || flush_req_i) ? ST_FLUSH : ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (flush_req_i) begin
          state_nxt = ST_FLUSH;
        end else if (arb_any) begin
          gnt_o      = arb_gnt;
          grant_fire = 1'b1;
        end
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  // Control state: FSM, sweep counter, round-robin pointer, coalesced flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RST_STATE;
      cnt           <= '0;
      rr_ptr        <= '0;
      flush_pending <= 1'b0;
    end else begin
      state <= state_nxt;
      if (sweep) begin
        cnt <= cnt + 1'b1;
        if (sweep_last)       flush_pending <= 1'b0;
        else if (flush_req_i) flush_pending <= 1'b1;
      end
      if (grant_fire) begin
        rr_ptr <= (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
      end
    end
  end

  // Registered write port: sweep zeroes, granted request, or idle hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else if (sweep) begin
      rf_we_o    <= 1'b1;
      rf_waddr_o <= cnt;
      rf_wdata_o <= '0;
    end else if (grant_fire) begin
      rf_we_o    <= 1'b1;
      rf_waddr_o <= addr_i[arb_idx];
      rf_wdata_o <= wdata_i[arb_idx];
    end else begin
      rf_we_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_icache_rf_write_ctrl.sv
// Directed bench for icache_rf_write_ctrl (ADDR_WIDTH=5, DATA_WIDTH=32, N_REQ=2).
module tb_icache_rf_write_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NR-1:0]          req_i;
  logic [NR-1:0][AW-1:0]  addr_i;
  logic [NR-1:0][DW-1:0]  wdata_i;
  logic [NR-1:0]          gnt_o;
  logic                   flush_req_i;
  logic                   busy_o;
  logic                   rf_we_o;
  logic [AW-1:0]          rf_waddr_o;
  logic [DW-1:0]          rf_wdata_o;

  int n_total = 0;
  int n_bad   = 0;

  icache_rf_write_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(NR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .flush_req_i (flush_req_i),
    .busy_o      (busy_o),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},    64'(rf_we_o),    64'd0);
    chk({tag, "_waddr"}, 64'(rf_waddr_o), 64'd0);
    chk({tag, "_wdata"}, 64'(rf_wdata_o), 64'd0);
    chk({tag, "_gnt"},   64'(gnt_o),      64'd0);
`ifdef ICACHE_RF_WCTRL_SKIP_INIT_EN
    chk({tag, "_busy"},  64'(busy_o),     64'd0);
`else
    chk({tag, "_busy"},  64'(busy_o),     64'd1);
`endif
  endtask

  initial begin
    rst_n       = 1'b0;
    req_i       = '0;
    addr_i      = '0;
    wdata_i     = '0;
    flush_req_i = 1'b0;
    #12;
    chk_reset_vals("rst");

    // Release reset away from the edge.
    @(posedge clk); #1;
    rst_n = 1'b1;

`ifndef ICACHE_RF_WCTRL_SKIP_INIT_EN
    // Init sweep: 32 zero writes, addresses 0..31, busy drops after 31.
    for (int k = 0; k < 32; k++) begin
      tick();
      chk($sformatf("init_we%0d", k),    64'(rf_we_o),    64'd1);
      chk($sformatf("init_addr%0d", k),  64'(rf_waddr_o), 64'(k));
      chk($sformatf("init_data%0d", k),  64'(rf_wdata_o), 64'd0);
      chk($sformatf("init_gnt%0d", k),   64'(gnt_o),      64'd0);
      chk($sformatf("init_busy%0d", k),  64'(busy_o),     (k < 31) ? 64'd1 : 64'd0);
    end
`endif
    tick();
    chk("idle_we", 64'(rf_we_o), 64'd0);
    chk("idle_busy", 64'(busy_o), 64'd0);

    // Single request from requester 0.
    req_i      = 2'b01;
    addr_i[0]  = 5'd7;
    wdata_i[0] = 32'hDEADBEEF;
    #1;
    chk("single_gnt", 64'(gnt_o), 64'h1);
    tick();
    chk("single_we",    64'(rf_we_o),    64'd1);
    chk("single_addr",  64'(rf_waddr_o), 64'd7);
    chk("single_data",  64'(rf_wdata_o), 64'hDEADBEEF);
    req_i = 2'b00;
    #1;
    chk("single_gnt_off", 64'(gnt_o), 64'h0);
    tick();
    chk("single_we_off",   64'(rf_we_o),    64'd0);
    chk("single_addr_hold", 64'(rf_waddr_o), 64'd7);

    // Requester 1 alone moves the pointer back to 0.
    req_i      = 2'b10;
    addr_i[1]  = 5'd3;
    wdata_i[1] = 32'h0000_0033;
    #1;
    chk("r1_gnt", 64'(gnt_o), 64'h2);
    tick();
    chk("r1_addr", 64'(rf_waddr_o), 64'd3);
    chk("r1_data", 64'(rf_wdata_o), 64'h33);

    // Both requesting with pointer 0: 01,10,01,10.
    req_i      = 2'b11;
    addr_i[0]  = 5'd5;  wdata_i[0] = 32'hA0A0_A0A0;
    addr_i[1]  = 5'd9;  wdata_i[1] = 32'hB1B1_B1B1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_gnt%0d", k), 64'(gnt_o), (k % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      chk($sformatf("rr_we%0d", k),   64'(rf_we_o),    64'd1);
      chk($sformatf("rr_addr%0d", k), 64'(rf_waddr_o), (k % 2 == 0) ? 64'd5 : 64'd9);
      chk($sformatf("rr_data%0d", k), 64'(rf_wdata_o),
          (k % 2 == 0) ? 64'hA0A0_A0A0 : 64'hB1B1_B1B1);
    end
    req_i = 2'b00;
    tick();
    chk("rr_we_off", 64'(rf_we_o), 64'd0);

    // Flush and request collide: no grant, full sweep, then grant.
    flush_req_i = 1'b1;
    req_i       = 2'b10;
    addr_i[1]   = 5'd17;
    wdata_i[1]  = 32'h0000_1234;
    #1;
    chk("fl_gnt_blocked", 64'(gnt_o), 64'h0);
    tick();
    flush_req_i = 1'b0;
    #1;
    chk("fl_we_none", 64'(rf_we_o), 64'd0);
    chk("fl_busy",    64'(busy_o),  64'd1);
    for (int k = 0; k < 32; k++) begin
      tick();
      chk($sformatf("fl_addr%0d", k), 64'(rf_waddr_o), 64'(k));
      chk($sformatf("fl_we%0d", k),   64'(rf_we_o),    64'd1);
      chk($sformatf("fl_data%0d", k), 64'(rf_wdata_o), 64'd0);
      chk($sformatf("fl_gnt%0d", k),  64'(gnt_o),      (k < 31) ? 64'h0 : 64'h2);
    end
    tick();
    chk("fl_post_we",   64'(rf_we_o),    64'd1);
    chk("fl_post_addr", 64'(rf_waddr_o), 64'd17);
    chk("fl_post_data", 64'(rf_wdata_o), 64'h1234);
    req_i = 2'b00;

    // Two pulses during a flush coalesce into one extra sweep (64 busy cycles).
    flush_req_i = 1'b1;
    tick();
    flush_req_i = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      chk($sformatf("dbl_addr%0d", k), 64'(rf_waddr_o), 64'((k - 1) % 32));
      chk($sformatf("dbl_we%0d", k),   64'(rf_we_o),    64'd1);
      chk($sformatf("dbl_busy%0d", k), 64'(busy_o),     (k < 64) ? 64'd1 : 64'd0);
      flush_req_i = (k == 3) || (k == 10);
    end
    flush_req_i = 1'b0;
    tick();
    chk("dbl_we_off", 64'(rf_we_o), 64'd0);

    // Reset in the middle of a sweep at address 12.
    flush_req_i = 1'b1;
    tick();
    flush_req_i = 1'b0;
    for (int k = 1; k <= 13; k++) tick();
    chk("mid_addr12", 64'(rf_waddr_o), 64'd12);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
`ifdef ICACHE_RF_WCTRL_SKIP_INIT_EN
    chk("restart_we",   64'(rf_we_o),    64'd0);
    chk("restart_busy", 64'(busy_o),     64'd0);
`else
    chk("restart_we",    64'(rf_we_o),    64'd1);
    chk("restart_addr0", 64'(rf_waddr_o), 64'd0);
    tick();
    chk("restart_addr1", 64'(rf_waddr_o), 64'd1);
    chk("restart_busy",  64'(busy_o),     64'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
